pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage core. It generates the decode-register control handshake: decode_control (0 = flush to bubble), decode_ready (0 = insert bubble, hold fetch/decode) and execute_allow_in (0 = freeze the execute register). It detects load-use hazards, branch mispredicts, CSR traps (ecall/mret) and multi-cycle execute operations, and keeps saturating stall/flush statistics.

---
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage core: load-use bubbles, mispredict/trap
// flushes, multi-cycle execute freezes, and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int MULTI_CYCLES = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic [4:0]           D_rs1_i,
    input  logic [4:0]           D_rs2_i,
    input  logic                 D_use_rs1_i,
    input  logic                 D_use_rs2_i,
    input  logic                 E_valid_i,
    input  logic                 E_load_i,
    input  logic                 E_need_dstE_i,
    input  logic [4:0]           E_dstE_i,
    input  logic                 E_mispredict_i,
    input  logic                 E_trap_i,
    input  logic                 E_multi_i,
    output logic                 fetch_control_o,
    output logic                 fetch_stall_o,
    output logic                 decode_control_o,
    output logic                 decode_ready_o,
    output logic                 execute_allow_in_o,
    output logic                 multi_done_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {RUN, MULTI, FLUSH} state_t;

    localparam logic [3:0] MULTI_LOAD = 4'(MULTI_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    logic multi_start, exec_allow, qual, mis, trp, lu_raw, lu, redirect;
    logic stall_ev, flush_ev;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        multi_start = (state_q == RUN) && E_valid_i && E_multi_i;
        exec_allow  = !(multi_start || (state_q == MULTI && cnt_q != 4'd0));
        // Execute-stage events only count when the execute register is not frozen
        // and we are not already draining a trap redirect.
        qual = exec_allow && (state_q != FLUSH);
        mis  = qual && E_valid_i && E_mispredict_i;
        trp  = qual && E_valid_i && E_trap_i;

        lu_raw = E_valid_i && E_load_i && E_need_dstE_i && (E_dstE_i != 5'd0) &&
                 ((D_use_rs1_i && D_rs1_i == E_dstE_i) ||
                  (D_use_rs2_i && D_rs2_i == E_dstE_i));
        lu       = qual && lu_raw;
        redirect = trp || mis;

        case (state_q)
            RUN: begin
                if (multi_start) begin
                    state_d = MULTI;
                    cnt_d   = MULTI_LOAD;
                end else if (trp) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            MULTI: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (trp) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase

        fetch_control_o    = !(redirect || state_q == FLUSH);
        decode_control_o   = !(redirect || state_q == FLUSH);
        decode_ready_o     = !(lu && !redirect);
        fetch_stall_o      = (lu && !redirect) || !exec_allow;
        execute_allow_in_o = exec_allow;
        multi_done_o       = (state_q == MULTI) && (cnt_q == 4'd0);
        flush_ev           = redirect;

        if (rst) begin
            state_d            = RUN;
            cnt_d              = 4'd0;
            fetch_control_o    = 1'b0;
            decode_control_o   = 1'b0;
            decode_ready_o     = 1'b1;
            execute_allow_in_o = 1'b1;
            fetch_stall_o      = 1'b0;
            multi_done_o       = 1'b0;
            flush_ev           = 1'b0;
        end

        stall_ev = !decode_ready_o || !execute_allow_in_o;
    end

    always_ff @(posedge clk_i) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // Statistics saturate rather than wrap.
            if (stall_ev && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_ev && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, multi-cycle freeze, mispredict,
// trap flush and mid-freeze reset, with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst;
    logic [4:0]  D_rs1_i, D_rs2_i, E_dstE_i;
    logic        D_use_rs1_i, D_use_rs2_i;
    logic        E_valid_i, E_load_i, E_need_dstE_i, E_mispredict_i, E_trap_i, E_multi_i;
    logic        fetch_control_o, fetch_stall_o, decode_control_o, decode_ready_o;
    logic        execute_allow_in_o, multi_done_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int checks_q = 0;
    int errors_q = 0;

    pipe_hazard_ctrl #(.MULTI_CYCLES(4), .FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut (
        .clk_i(clk_i), .rst(rst),
        .D_rs1_i(D_rs1_i), .D_rs2_i(D_rs2_i),
        .D_use_rs1_i(D_use_rs1_i), .D_use_rs2_i(D_use_rs2_i),
        .E_valid_i(E_valid_i), .E_load_i(E_load_i), .E_need_dstE_i(E_need_dstE_i),
        .E_dstE_i(E_dstE_i), .E_mispredict_i(E_mispredict_i), .E_trap_i(E_trap_i),
        .E_multi_i(E_multi_i),
        .fetch_control_o(fetch_control_o), .fetch_stall_o(fetch_stall_o),
        .decode_control_o(decode_control_o), .decode_ready_o(decode_ready_o),
        .execute_allow_in_o(execute_allow_in_o), .multi_done_o(multi_done_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_q++;
        if (obs !== exp) begin
            errors_q++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic idle();
        D_rs1_i = 0; D_rs2_i = 0; D_use_rs1_i = 0; D_use_rs2_i = 0;
        E_valid_i = 0; E_load_i = 0; E_need_dstE_i = 0; E_dstE_i = 0;
        E_mispredict_i = 0; E_trap_i = 0; E_multi_i = 0;
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic set_lu_rs2_x5();
        E_valid_i = 1; E_load_i = 1; E_need_dstE_i = 1; E_dstE_i = 5;
        D_rs2_i = 5; D_use_rs2_i = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        E_valid_i = 1; E_multi_i = 1;
        step();
        step();
        chk("rst_fetch_control", fetch_control_o, 0);
        chk("rst_decode_control", decode_control_o, 0);
        chk("rst_decode_ready", decode_ready_o, 1);
        chk("rst_exec_allow", execute_allow_in_o, 1);
        chk("rst_fetch_stall", fetch_stall_o, 0);
        chk("rst_multi_done", multi_done_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);

        // Load-use on rs2 = x5: one bubble
        @(negedge clk_i); rst = 0; idle(); set_lu_rs2_x5(); #1;
        chk("lu_decode_ready", decode_ready_o, 0);
        chk("lu_fetch_stall", fetch_stall_o, 1);
        chk("lu_decode_control", decode_control_o, 1);
        chk("lu_fetch_control", fetch_control_o, 1);
        @(negedge clk_i); idle(); #1;
        chk("lu_after_ready", decode_ready_o, 1);
        chk("lu_stall_cnt", stall_cnt_o, 1);

        // x0 destination never stalls
        @(negedge clk_i);
        E_valid_i = 1; E_load_i = 1; E_need_dstE_i = 1; E_dstE_i = 0;
        D_rs1_i = 0; D_use_rs1_i = 1; #1;
        chk("x0_decode_ready", decode_ready_o, 1);
        chk("x0_fetch_stall", fetch_stall_o, 0);
        // rs1 matches but is not read
        @(negedge clk_i); E_dstE_i = 7; D_rs1_i = 7; D_use_rs1_i = 0; #1;
        chk("nouse_decode_ready", decode_ready_o, 1);
        @(negedge clk_i); idle(); #1;
        chk("x0_stall_cnt", stall_cnt_o, 1);

        // Multi-cycle op: frozen 4 cycles, release pulse on the 5th
        @(negedge clk_i); E_valid_i = 1; E_multi_i = 1; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("multi_freeze%0d", i), execute_allow_in_o, 0);
            chk($sformatf("multi_stall%0d", i), fetch_stall_o, 1);
            chk($sformatf("multi_nodone%0d", i), multi_done_o, 0);
            step();
        end
        chk("multi_release_allow", execute_allow_in_o, 1);
        chk("multi_release_done", multi_done_o, 1);
        @(negedge clk_i); idle(); #1;
        chk("multi_stall_cnt", stall_cnt_o, 5);
        chk("multi_run_allow", execute_allow_in_o, 1);
        chk("multi_run_done", multi_done_o, 0);

        // Mispredict beats a coincident load-use
        @(negedge clk_i); set_lu_rs2_x5(); E_mispredict_i = 1; #1;
        chk("mis_decode_control", decode_control_o, 0);
        chk("mis_fetch_control", fetch_control_o, 0);
        chk("mis_decode_ready", decode_ready_o, 1);
        chk("mis_fetch_stall", fetch_stall_o, 0);
        @(negedge clk_i); idle(); #1;
        chk("mis_flush_cnt", flush_cnt_o, 1);
        chk("mis_stall_cnt", stall_cnt_o, 5);
        chk("mis_after_control", decode_control_o, 1);

        // Trap: event cycle plus two FLUSH cycles; events during FLUSH ignored
        @(negedge clk_i); E_valid_i = 1; E_trap_i = 1; #1;
        chk("trp_fetch_control", fetch_control_o, 0);
        chk("trp_decode_control", decode_control_o, 0);
        @(negedge clk_i); idle(); set_lu_rs2_x5(); E_mispredict_i = 1; #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("flush_fetch_control%0d", i), fetch_control_o, 0);
            chk($sformatf("flush_decode_control%0d", i), decode_control_o, 0);
            chk($sformatf("flush_decode_ready%0d", i), decode_ready_o, 1);
            step();
        end
        idle(); #1;
        chk("trp_done_fetch_control", fetch_control_o, 1);
        chk("trp_done_decode_control", decode_control_o, 1);
        chk("trp_flush_cnt", flush_cnt_o, 2);
        chk("trp_stall_cnt", stall_cnt_o, 5);

        // Reset during cycle 2 of MULTI
        @(negedge clk_i); E_valid_i = 1; E_multi_i = 1; #1;
        chk("mrst_freeze", execute_allow_in_o, 0);
        @(negedge clk_i); idle(); rst = 1; #1;
        chk("mrst_during_allow", execute_allow_in_o, 1);
        @(negedge clk_i); rst = 0; #1;
        chk("mrst_allow", execute_allow_in_o, 1);
        chk("mrst_fetch_stall", fetch_stall_o, 0);
        chk("mrst_stall_cnt", stall_cnt_o, 0);
        chk("mrst_flush_cnt", flush_cnt_o, 0);
        step();
        chk("mrst_run_allow", execute_allow_in_o, 1);
        chk("mrst_run_done", multi_done_o, 0);
        chk("mrst_run_stall_cnt", stall_cnt_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
        $finish;
    end

endmodule
